// File: rtl/cve2_obi_mem_resp.sv
// -----------------------------------------------------------------------------
// cve2_obi_mem_resp
//
// Single-port behavioural memory acting as the target of the core's
// req/gnt/rvalid memory protocol. Requests are granted combinationally,
// in-range writes update the array with byte enables at the end of the grant
// cycle, and every granted request gets exactly one response after a fixed
// RespLatency cycles, in grant order. Out-of-range requests touch nothing and
// return an error. The number of granted-but-unanswered requests is capped at
// MaxOutstanding.
//
// Parameters:
//   MemWords       - number of 32-bit words in the array (>= 1)
//   BaseAddr       - byte address of word 0 (word aligned)
//   RespLatency    - cycles from grant to rvalid_o (>= 1)
//   MaxOutstanding - cap on granted-but-unanswered requests (>= 1)
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   stall_i        - suppresses gnt_o (back-pressure injection)
//   req_i, gnt_o   - request / combinational grant
//   we_i, be_i     - write enable, byte enables (bit n -> wdata_i[8n+7:8n])
//   addr_i         - byte address, bits [1:0] ignored
//   wdata_i        - write data
//   rvalid_o       - one-cycle response strobe per granted request
//   rdata_o, err_o - response payload, zero when rvalid_o is low
//   outstanding_o  - current granted-but-unanswered count
// -----------------------------------------------------------------------------
module cve2_obi_mem_resp #(
  parameter int unsigned MemWords       = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  output logic            rvalid_o,
  output logic [31:0]     rdata_o,
  output logic            err_o,
  output logic [CntW-1:0] outstanding_o
);

  // A one-word array still needs a 1-bit index.
  localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
  // Array size in bytes, one bit wider than an address so 4 GiB still fits.
  localparam logic [32:0] MemBytes = 33'(MemWords) * 33'd4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic [31:0]     mem_q [MemWords];
  resp_t           pipe_q [RespLatency];
  resp_t           resp_in;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0]     off;
  logic            in_range;
  logic [IdxW-1:0] word_idx;
  logic            grant;

  // ---------------------------------------------------------------------------
  // Address decode. An address below BaseAddr wraps to a huge offset and so
  // falls out of range through the same unsigned compare.
  // ---------------------------------------------------------------------------
  assign off      = addr_i - BaseAddr;
  assign in_range = {1'b0, off} < MemBytes;
  assign word_idx = off[IdxW+1:2];

  // ---------------------------------------------------------------------------
  // Grant. A retiring response frees a slot in the same cycle, so a full
  // responder can still accept one request whenever rvalid_o is high.
  // ---------------------------------------------------------------------------
  assign gnt_o = req_i & ~stall_i &
                 ((cnt_q < CntW'(MaxOutstanding)) | rvalid_o);
  assign grant = gnt_o;

  // ---------------------------------------------------------------------------
  // Memory array. Read is sampled combinationally in the grant cycle, so it
  // sees the contents before that edge's write (a single port never reads and
  // writes in the same cycle anyway).
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; contents persist across rst_ni and are only
  // defined by writes or a simulation preload, which keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (grant && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response entering stage 0; all-zero when nothing is granted so that the
  // final stage presents rdata_o = 0 and err_o = 0 whenever it is not valid.
  always_comb begin
    resp_in = '0;
    if (grant) begin
      resp_in.valid = 1'b1;
      if (!in_range) begin
        resp_in.err = 1'b1;
      end else if (!we_i) begin
        resp_in.rdata = mem_q[word_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: RespLatency stages, no back-pressure.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RespLatency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= resp_in;
      for (int i = 1; i < RespLatency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rvalid_o = pipe_q[RespLatency-1].valid;
  assign err_o    = pipe_q[RespLatency-1].err;
  assign rdata_o  = pipe_q[RespLatency-1].rdata;

  // ---------------------------------------------------------------------------
  // Outstanding counter. Grant and retire in the same cycle cancel out; the
  // guards keep the count inside [0, MaxOutstanding] even on misuse.
  // ---------------------------------------------------------------------------
  // NOTE: cnt_d gets its default first so every path assigns it and no latch
  // is inferred.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({grant, rvalid_o})
      2'b10: if (cnt_q < CntW'(MaxOutstanding)) cnt_d = cnt_q + 1'b1;
      2'b01: if (cnt_q != '0)                   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign outstanding_o = cnt_q;

endmodule
